// File: rtl/pkg_ula.sv
// Shared types and widths for the 16-bit logic unit operand path.
package pkg_ula;
  localparam int LARGURA_PALAVRA = 16;
  localparam int LARGURA_BYTE    = 8;

  typedef enum logic [2:0] {
    LE_A0 = 3'd0,
    LE_A1 = 3'd1,
    LE_B0 = 3'd2,
    LE_B1 = 3'd3,
    CHEIO = 3'd4
  } estado_t;
endpackage

// File: rtl/contador_pares_8bit.sv
// Wrapping count of operand pairs consumed downstream.
module contador_pares_8bit #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hab,
  input  logic               limpar,
  output logic [LARGURA-1:0] cont
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cont <= '0;
    else if (limpar) cont <= '0;
    else if (hab)    cont <= cont + 1'b1;
  end
endmodule

// File: rtl/carregador_operandos_16bit.sv
// Collects four bytes into a stable A/B operand pair and hands it downstream.
module carregador_operandos_16bit
  import pkg_ula::*;
#(
  parameter bit ORDEM_MSB_PRIMEIRO = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       limpar,
  input  logic [LARGURA_BYTE-1:0]    dado_in,
  input  logic                       dado_in_valido,
  output logic                       dado_in_pronto,
  output logic [LARGURA_PALAVRA-1:0] a,
  output logic [LARGURA_PALAVRA-1:0] b,
  output logic                       operandos_validos,
  input  logic                       operandos_aceitos,
  output logic [7:0]                 cont_pares,
  output logic                       erro_sobrecarga
);
  estado_t                    estado;
  logic [LARGURA_PALAVRA-1:0] sombra_a;
  logic [LARGURA_BYTE-1:0]    sombra_b;
  logic [LARGURA_PALAVRA-1:0] par_b;
  logic                       transf;
  logic                       hab_cont;

  assign dado_in_pronto    = (estado != CHEIO);
  assign operandos_validos = (estado == CHEIO);
  assign transf            = dado_in_valido && dado_in_pronto;
  assign hab_cont          = operandos_validos && operandos_aceitos && !limpar;

  // The 4th byte goes straight into B so the pair lands on the CHEIO edge.
  assign par_b = ORDEM_MSB_PRIMEIRO ? {sombra_b, dado_in} : {dado_in, sombra_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= LE_A0;
      sombra_a        <= '0;
      sombra_b        <= '0;
      a               <= '0;
      b               <= '0;
      erro_sobrecarga <= 1'b0;
    end else if (limpar) begin
      estado          <= LE_A0;
      sombra_a        <= '0;
      sombra_b        <= '0;
      a               <= '0;
      b               <= '0;
      erro_sobrecarga <= 1'b0;
    end else begin
      case (estado)
        LE_A0: if (transf) begin
          if (ORDEM_MSB_PRIMEIRO) sombra_a[15:8] <= dado_in;
          else                    sombra_a[7:0]  <= dado_in;
          estado <= LE_A1;
        end
        LE_A1: if (transf) begin
          if (ORDEM_MSB_PRIMEIRO) sombra_a[7:0]  <= dado_in;
          else                    sombra_a[15:8] <= dado_in;
          estado <= LE_B0;
        end
        LE_B0: if (transf) begin
          sombra_b <= dado_in;
          estado   <= LE_B1;
        end
        LE_B1: if (transf) begin
          a      <= sombra_a;
          b      <= par_b;
          estado <= CHEIO;
        end
        CHEIO: begin
          if (dado_in_valido)    erro_sobrecarga <= 1'b1;
          if (operandos_aceitos) estado          <= LE_A0;
        end
        default: estado <= LE_A0;
      endcase
    end
  end

  contador_pares_8bit #(.LARGURA(8)) u_cont (
    .clk    (clk),
    .rst_n  (rst_n),
    .hab    (hab_cont),
    .limpar (limpar),
    .cont   (cont_pares)
  );
endmodule

// File: tb/tb_carregador_operandos_16bit.sv
// Drives both byte orders from one stream and compares against a byte-queue model.
module tb_carregador_operandos_16bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic limpar = 1'b0;
  logic [7:0] dado_in = 8'h00;
  logic dado_in_valido = 1'b0;
  logic operandos_aceitos = 1'b0;

  logic pronto0, val0, err0, pronto1, val1, err1;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0] cont0, cont1;

  int checks = 0;
  int errors = 0;

  // model: bytes received for the current pair, loaded operands, counters
  logic [7:0]  q[$];
  logic [15:0] m_a[2];
  logic [15:0] m_b[2];
  logic [7:0]  m_cont;
  logic        m_err;

  always #5 clk = ~clk;

  carregador_operandos_16bit #(.ORDEM_MSB_PRIMEIRO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .limpar(limpar), .dado_in(dado_in),
    .dado_in_valido(dado_in_valido), .dado_in_pronto(pronto0), .a(a0), .b(b0),
    .operandos_validos(val0), .operandos_aceitos(operandos_aceitos),
    .cont_pares(cont0), .erro_sobrecarga(err0));

  carregador_operandos_16bit #(.ORDEM_MSB_PRIMEIRO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .limpar(limpar), .dado_in(dado_in),
    .dado_in_valido(dado_in_valido), .dado_in_pronto(pronto1), .a(a1), .b(b1),
    .operandos_validos(val1), .operandos_aceitos(operandos_aceitos),
    .cont_pares(cont1), .erro_sobrecarga(err1));

  function automatic void model_clear();
    q.delete();
    for (int i = 0; i < 2; i++) begin m_a[i] = 16'h0; m_b[i] = 16'h0; end
    m_cont = 8'h0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_edge();
    int v;
    if (!rst_n) return;
    if (limpar) begin model_clear(); return; end
    if (q.size() < 4) begin
      if (dado_in_valido) begin
        q.push_back(dado_in);
        if (q.size() == 4) begin
          v = int'(q[0]) + 256 * int'(q[1]); m_a[0] = v[15:0];
          v = int'(q[2]) + 256 * int'(q[3]); m_b[0] = v[15:0];
          v = 256 * int'(q[0]) + int'(q[1]); m_a[1] = v[15:0];
          v = 256 * int'(q[2]) + int'(q[3]); m_b[1] = v[15:0];
        end
      end
    end else begin
      if (dado_in_valido) m_err = 1'b1;
      if (operandos_aceitos) begin
        q.delete();
        v = (int'(m_cont) + 1) % 256;
        m_cont = v[7:0];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic acc, input logic clr);
    dado_in_valido = v; dado_in = d; operandos_aceitos = acc; limpar = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    #1 model_clear();
    tick(); // edge during reset must not transfer
    checks++; if (pronto0 !== 1'b1 || pronto1 !== 1'b1) begin errors++;
      $display("FAIL reset_pronto got %b/%b want 1", pronto0, pronto1); end
    checks++; if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || b1 !== 16'h0) begin errors++;
      $display("FAIL reset_ab got %h %h %h %h want 0", a0, b0, a1, b1); end
    checks++; if (val0 !== 1'b0 || cont0 !== 8'h0 || err0 !== 1'b0) begin errors++;
      $display("FAIL reset_flags got val=%b cont=%h err=%b want 0", val0, cont0, err0); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_lsb_seq();
    logic [7:0] bs[4];
    bs = '{8'h34, 8'h12, 8'h0F, 8'hF0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bs[i], 1'b0, 1'b0);
      tick();
      if (i < 3) begin
        checks++; if (a0 !== 16'h0 || b0 !== 16'h0 || val0 !== 1'b0) begin errors++;
          $display("FAIL lsb_early byte%0d got a=%h b=%h val=%b want 0", i, a0, b0, val0); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (a0 !== 16'h1234 || b0 !== 16'hF00F || val0 !== 1'b1) begin errors++;
      $display("FAIL lsb_pair got a=%h b=%h val=%b want 1234 f00f 1", a0, b0, val0); end
    checks++; if (a1 !== m_a[1] || b1 !== m_b[1]) begin errors++;
      $display("FAIL lsb_pair_msbinst got a=%h b=%h want %h %h", a1, b1, m_a[1], m_b[1]); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++; if (val0 !== 1'b0 || pronto0 !== 1'b1 || a0 !== 16'h1234) begin errors++;
      $display("FAIL lsb_accept got val=%b pronto=%b a=%h", val0, pronto0, a0); end
  endtask

  task automatic test_msb_gaps();
    logic [7:0] bs[4];
    bs = '{8'h12, 8'h34, 8'hF0, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive(1'b0, 8'($urandom), 1'b0, 1'b0);
        tick();
        checks++; if (pronto1 !== 1'b1 || val1 !== 1'b0) begin errors++;
          $display("FAIL msb_gap byte%0d got pronto=%b val=%b want 1 0", i, pronto1, val1); end
      end
      drive(1'b1, bs[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (a1 !== 16'h1234 || b1 !== 16'hF00F || val1 !== 1'b1) begin errors++;
      $display("FAIL msb_pair got a=%h b=%h val=%b want 1234 f00f 1", a1, b1, val1); end
    checks++; if (a0 !== m_a[0] || b0 !== m_b[0]) begin errors++;
      $display("FAIL msb_pair_lsbinst got a=%h b=%h want %h %h", a0, b0, m_a[0], m_b[0]); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_overflow();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      tick();
      checks++; if (pronto0 !== 1'b0 || pronto1 !== 1'b0 || val0 !== 1'b1) begin errors++;
        $display("FAIL ovf_pronto cyc%0d got %b/%b val=%b want 0 0 1", i, pronto0, pronto1, val0); end
      checks++; if (a0 !== m_a[0] || b0 !== m_b[0] || a1 !== m_a[1] || b1 !== m_b[1]) begin errors++;
        $display("FAIL ovf_hold cyc%0d got %h %h %h %h", i, a0, b0, a1, b1); end
      checks++; if (err0 !== 1'b1 || err1 !== 1'b1) begin errors++;
        $display("FAIL ovf_err cyc%0d got %b/%b want 1", i, err0, err1); end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++; if (cont0 !== 8'd1 || pronto0 !== 1'b1 || val0 !== 1'b0 || err0 !== 1'b1) begin errors++;
      $display("FAIL ovf_accept got cont=%h pronto=%b val=%b err=%b want 01 1 0 1", cont0, pronto0, val0, err0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
      tick();
      checks++; if (pronto0 !== (q.size() < 4) || val0 !== (q.size() == 4) ||
                    pronto1 !== (q.size() < 4) || val1 !== (q.size() == 4)) begin errors++;
        $display("FAIL rnd_hs cyc%0d got p=%b%b v=%b%b n=%0d", i, pronto0, pronto1, val0, val1, q.size()); end
      checks++; if (a0 !== m_a[0] || b0 !== m_b[0] || a1 !== m_a[1] || b1 !== m_b[1]) begin errors++;
        $display("FAIL rnd_ab cyc%0d got %h %h %h %h want %h %h %h %h", i, a0, b0, a1, b1,
                 m_a[0], m_b[0], m_a[1], m_b[1]); end
      checks++; if (cont0 !== m_cont || cont1 !== m_cont || err0 !== m_err || err1 !== m_err) begin errors++;
        $display("FAIL rnd_cnt cyc%0d got cont=%h err=%b want %h %b", i, cont0, err0, m_cont, m_err); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick();
      end
      checks++; if (a0 !== m_a[0] || b0 !== m_b[0] || a1 !== m_a[1] || b1 !== m_b[1] || val0 !== 1'b1) begin errors++;
        $display("FAIL b2b_pair%0d got %h %h %h %h val=%b", p, a0, b0, a1, b1, val0); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      if (p == 254) begin
        checks++; if (cont0 !== 8'd255) begin errors++;
          $display("FAIL b2b_255 got %h want ff", cont0); end
      end
    end
    checks++; if (cont0 !== 8'd0 || cont1 !== 8'd0) begin errors++;
      $display("FAIL b2b_wrap got %h/%h want 00", cont0, cont1); end
  endtask

  task automatic test_limpar_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h33, 1'b0, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || b1 !== 16'h0 || cont0 !== 8'h0) begin errors++;
      $display("FAIL limpar_clear got %h %h %h %h cont=%h want 0", a0, b0, a1, b1, cont0); end
    checks++; if (pronto0 !== 1'b1 || val0 !== 1'b0 || err0 !== 1'b0) begin errors++;
      $display("FAIL limpar_state got pronto=%b val=%b err=%b want 1 0 0", pronto0, val0, err0); end
    drive(1'b1, 8'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hD4, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (a0 !== 16'hB2A1 || b0 !== 16'hD4C3 || a1 !== 16'hA1B2 || b1 !== 16'hC3D4) begin errors++;
      $display("FAIL limpar_reload got %h %h %h %h want b2a1 d4c3 a1b2 c3d4", a0, b0, a1, b1); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h88, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_clear();
    checks++; if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || cont0 !== 8'h0 || val0 !== 1'b0 || pronto0 !== 1'b1) begin errors++;
      $display("FAIL rstmid_now got a=%h b=%h cont=%h val=%b pronto=%b", a0, b0, cont0, val0, pronto0); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (a0 !== m_a[0] || b0 !== m_b[0] || a1 !== m_a[1] || b1 !== m_b[1] || val1 !== 1'b1) begin errors++;
      $display("FAIL rstmid_reload got %h %h %h %h want %h %h %h %h", a0, b0, a1, b1,
               m_a[0], m_b[0], m_a[1], m_b[1]); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_lsb_seq();
    test_msb_gaps();
    test_overflow();
    test_random();
    test_back_to_back();
    test_limpar_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/carregador_operandos_16bit.md
CARREGADOR_OPERANDOS_16BIT -- requirements
Module: carregador_operandos_16bit

Interface
REQ-001 Parameter: ORDEM_MSB_PRIMEIRO, 0, byte order within each operand (0 = low byte first, 1 = high byte first).
REQ-002 CLK  in  1  single clock, all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 LIMPAR  in  1  synchronous abort/clear.
REQ-005 DADO_IN  in  8  operand byte from upstream.
REQ-006 DADO_IN_VALIDO  in  1  DADO_IN holds a valid byte.
REQ-007 DADO_IN_PRONTO  out  1  block can accept a byte.
REQ-008 A  out  16  operand A to the 16-bit logic unit.
REQ-009 B  out  16  operand B to the 16-bit logic unit.
REQ-010 OPERANDOS_VALIDOS  out  1  A/B hold a complete, stable operand pair.
REQ-011 OPERANDOS_ACEITOS  in  1  downstream has consumed the pair.
REQ-012 CONT_PARES  out  8  count of pairs consumed.
REQ-013 ERRO_SOBRECARGA  out  1  sticky flag: byte offered while full.

Function
REQ-014 The block SHALL use states LE_A0, LE_A1, LE_B0, LE_B1, CHEIO.
REQ-015 A byte SHALL be transferred on a rising edge with DADO_IN_VALIDO=1 and DADO_IN_PRONTO=1.
REQ-016 DADO_IN_PRONTO SHALL be 1 in LE_A0..LE_B1 and 0 in CHEIO, decoded from state only.
REQ-017 Each transfer SHALL advance LE_A0->LE_A1->LE_B0->LE_B1->CHEIO. No transfer means the state holds.
REQ-018 With ORDEM_MSB_PRIMEIRO=0, bytes SHALL map to A[7:0], A[15:8], B[7:0], B[15:8]. With 1, they map to A[15:8], A[7:0], B[15:8], B[7:0].
REQ-019 Bytes SHALL collect in internal shadow registers. A and B SHALL change only on the edge entering CHEIO, both 16 bits updating together.
REQ-020 OPERANDOS_VALIDOS SHALL be 1 exactly while in CHEIO. It rises the cycle after the 4th transfer.
REQ-021 In CHEIO with OPERANDOS_ACEITOS=1:
  - next state LE_A0;
  - OPERANDOS_VALIDOS drops next cycle;
  - A/B hold their values until the next pair loads;
  - CONT_PARES increments by 1, wrapping 255->0.
REQ-022 OPERANDOS_ACEITOS outside CHEIO SHALL be ignored.
REQ-023 Minimum period SHALL be 5 cycles per pair: 4 transfers plus 1 accept cycle. There is no bypass.
REQ-024 DADO_IN_VALIDO=1 while in CHEIO SHALL set ERRO_SOBRECARGA on that edge. The byte is discarded and the flag holds until LIMPAR or reset.
REQ-025 LIMPAR=1 SHALL take priority over every other event:
  - next state LE_A0;
  - shadow, A, B and ERRO_SOBRECARGA cleared to 0;
  - CONT_PARES cleared to 0;
  - any simultaneous byte transfer or accept is discarded.
REQ-026 RST_N asserted mid-sequence SHALL discard the partial pair immediately.

Reset
REQ-027 While RST_N=0, state SHALL be LE_A0 and the outputs SHALL be:
  - A=0, B=0;
  - OPERANDOS_VALIDOS=0, CONT_PARES=0, ERRO_SOBRECARGA=0;
  - DADO_IN_PRONTO=1, as decoded from LE_A0.
REQ-028 No transfer SHALL occur on an edge while RST_N=0. Normal operation SHALL begin on the first rising edge after release.

Structure
REQ-029 Package pkg_ula SHALL hold the state encoding typedef and constants LARGURA_PALAVRA=16 and LARGURA_BYTE=8.
REQ-030 The pair counter SHALL be sub-module contador_pares_8bit, with enable, synchronous clear and wrap. All other logic is in the top module.

Verification
REQ-031 Reset release, ORDEM_MSB_PRIMEIRO=0, bytes 0x34,0x12,0x0F,0xF0 on consecutive cycles -> A=0x1234, B=0xF00F, OPERANDOS_VALIDOS=1 the cycle after the 4th byte; A/B unchanged before then.
REQ-032 ORDEM_MSB_PRIMEIRO=1, bytes 0x12,0x34,0xF0,0x0F -> A=0x1234, B=0xF00F. DADO_IN_VALIDO gaps between bytes -> same result, state held during gaps.
REQ-033 In CHEIO, hold OPERANDOS_ACEITOS=0 for 3 cycles with DADO_IN_VALIDO=1 and DADO_IN=0xAA -> DADO_IN_PRONTO=0, A/B unchanged, ERRO_SOBRECARGA=1. Then accept -> LE_A0, CONT_PARES=1.
REQ-034 256 back-to-back pairs at 5 cycles/pair -> CONT_PARES wraps to 0. Assert LIMPAR together with the 3rd byte of a pair -> byte discarded, state LE_A0, A=B=0, CONT_PARES=0.
REQ-035 RST_N pulsed low after 2 bytes -> outputs at reset values immediately. A following full 4-byte sequence loads correctly.
